// File: rtl/edp_mul_seq.sv
// Sequential shift-add multiplier: one product bit per clock, WIDTH steps, held until acknowledged.
// Define EDP_MUL_SEQ_OVF_EN to add the registered overflow output.
module edp_mul_seq #(
  parameter int WIDTH = 36
) (
  input  logic                           eboxClk,
  input  logic                           eboxReset_n,
  input  logic                           start,
  input  logic                           signedMode,
  input  logic [0:WIDTH-1]               BRin,
  input  logic [0:WIDTH-1]               MQin,
  input  logic                           abort,
  input  logic                           resultAck,
  output logic                           ready,
  output logic                           busy,
  output logic                           resultValid,
  output logic [0:WIDTH-1]               MUL_AR,
  output logic [0:WIDTH-1]               MUL_MQ,
  output logic [0:$clog2(WIDTH+1)-1]     stepCount
`ifdef EDP_MUL_SEQ_OVF_EN
  ,
  output logic                           overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  // One-hot encoding so ready/busy/resultValid come straight from flops.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  ar_q, mq_q, br_q;
  logic [CW-1:0]     cnt_q;
  logic              sgn_q;
  logic              steps_done;
  logic              last_step;
  logic [WIDTH:0]    ar_ext, addend, sum;

  assign steps_done = (cnt_q == CW'(WIDTH));
  assign last_step  = sgn_q && (cnt_q == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge eboxClk) begin
    if (!eboxReset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // NOTE: always_comb blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)           state_d = IDLE;
        else if (steps_done) state_d = DONE;
      end
      DONE:    if (resultAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready       = state_q[0];
    busy        = state_q[1];
    resultValid = state_q[2];
  end

  // The signed-mode final step subtracts: the multiplier's top bit carries weight -2^(WIDTH-1).
  always_comb begin
    ar_ext = {sgn_q & ar_q[WIDTH-1], ar_q};
    addend = mq_q[0] ? {sgn_q & br_q[WIDTH-1], br_q} : '0;
    sum    = last_step ? (ar_ext - addend) : (ar_ext + addend);
  end

  // The WIDTH+1-bit sum already holds the sign/carry, so the shift-in fill bit falls off the top.
  always_ff @(posedge eboxClk) begin
    if (!eboxReset_n) begin
      ar_q  <= '0;
      mq_q  <= '0;
      br_q  <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ar_q  <= '0;
            mq_q  <= MQin;
            br_q  <= BRin;
            cnt_q <= '0;
            sgn_q <= signedMode;
          end
        end
        RUN: begin
          if (!abort && !steps_done) begin
            ar_q  <= sum[WIDTH:1];
            mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EDP_MUL_SEQ_OVF_EN
  // Evaluated on the edge entering DONE, when AR/MQ already hold the final product.
  always_ff @(posedge eboxClk) begin
    if (!eboxReset_n) begin
      overflow <= 1'b0;
    end else if (state_q == IDLE && start) begin
      overflow <= 1'b0;
    end else if (state_q == RUN && !abort && steps_done) begin
      overflow <= sgn_q ? (ar_q != {WIDTH{mq_q[WIDTH-1]}}) : (ar_q != '0);
    end
  end
`endif

  assign MUL_AR    = ar_q;
  assign MUL_MQ    = mq_q;
  assign stepCount = cnt_q;

endmodule
